// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM encoding and
// the iteration-counter width helper.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Counter must hold the value N itself, hence the extra bit.
  function automatic int count_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/adder_substractor.sv
// n-bit two's-complement adder/subtractor: s = x + y when add_n = 0,
// s = x - y when add_n = 1.
module adder_substractor #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         overflow
);

  logic [n-1:0] w_y_inv;

  // Subtraction reuses the adder as x + ~y + 1.
  assign w_y_inv       = y ^ {n{add_n}};
  assign {cout, s}     = {1'b0, x} + {1'b0, w_y_inv} + {{n{1'b0}}, add_n};
  assign overflow      = (x[n-1] == w_y_inv[n-1]) && (s[n-1] != x[n-1]);

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub/no-op plus arithmetic
// shift right per cycle on an N+1-bit partial product; result after N cycles.
module booth_multiplier_seq
  import booth_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = count_w(N);

  state_t              r_state;
  state_t              w_next;
  logic signed [N:0]   r_a;
  logic signed [N:0]   r_mx;
  logic [N-1:0]        r_q;
  logic                r_q1;
  logic [CW-1:0]       r_count;
  logic [2*N-1:0]      r_product;
  logic                r_busy;
  logic                r_done;

  logic                w_add_n;
  logic [N:0]          w_sum;
  logic [N:0]          w_a_sel;
  logic [N:0]          w_a_sh;
  logic [N-1:0]        w_q_sh;
  logic                w_q1_sh;
  logic                w_last;
  logic                w_unused_cout;
  logic                w_unused_ovf;

  // Booth decode: 10 subtracts, 01 adds, 00/11 keep A.
  assign w_add_n = r_q[0] & ~r_q1;

  adder_substractor #(
    .n(N + 1)
  ) u_addsub (
    .x       (r_a),
    .y       (r_mx),
    .add_n   (w_add_n),
    .s       (w_sum),
    .cout    (w_unused_cout),
    .overflow(w_unused_ovf)
  );

  assign w_a_sel = (r_q[0] ^ r_q1) ? w_sum : r_a;

  // Arithmetic shift right of {A', Q, q_1}, replicating the sign of A'.
  assign {w_a_sh, w_q_sh, w_q1_sh} = {w_a_sel[N], w_a_sel, r_q};

  assign w_last = (r_count == CW'(N - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE:             w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_mx      <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_RUN);
      r_done  <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= '0;
            r_mx    <= {multiplicand[N-1], multiplicand};
            r_q     <= multiplier;
            r_q1    <= 1'b0;
            r_count <= '0;
          end
        end
        ST_RUN: begin
          r_a     <= w_a_sh;
          r_q     <= w_q_sh;
          r_q1    <= w_q1_sh;
          r_count <= r_count + CW'(1);
          if (w_last) r_product <= {w_a_sh[N-1:0], w_q_sh};
        end
        default: ;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq (N=4) using a result scoreboard.
module tb_booth_multiplier_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] multiplicand = '0;
  logic [3:0] multiplier = '0;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0;
  logic [7:0] sb[$];

  booth_multiplier_seq #(.N(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done pops one expected product.
  always @(negedge clk) begin
    if (reset_n && done === 1'b1) begin
      logic [7:0] exp_p;
      n_done++;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected_done: product=%h with no pending result", product);
      end else begin
        exp_p = sb.pop_front();
        if (product !== exp_p) begin
          n_errors++;
          $display("FAIL sb_product: got %h expected %h", product, exp_p);
        end
      end
    end
  end

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s_timeout: done got 0 expected 1 within 40 cycles", name);
    end
  endtask

  task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp_p,
                        input string name);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    sb.push_back(exp_p);
    @(negedge clk);
    start = 1'b0;
    wait_done(name);
    n_checks++;
    if (product !== exp_p) begin
      n_errors++;
      $display("FAIL %s: product got %h expected %h", name, product, exp_p);
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({busy, done, product} !== 10'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: busy=%b done=%b product=%h expected 0/0/00", busy, done, product);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    @(negedge clk);
    multiplicand = 4'd3;
    multiplier   = 4'd2;
    start        = 1'b1;
    sb.push_back(8'h06);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (busy !== (k < 4) || done !== (k == 4)) begin
        n_errors++;
        $display("FAIL basic_timing_k%0d: busy=%b done=%b expected busy=%b done=%b",
                 k, busy, done, k < 4, k == 4);
      end
      if (k == 4) begin
        n_checks++;
        if (product !== 8'h06) begin
          n_errors++;
          $display("FAIL basic_product: got %h expected 06", product);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_patterns;
    logic [3:0] tm[5] = '{4'hD, 4'h7, 4'h0, 4'h5, 4'h8};
    logic [3:0] tq[5] = '{4'h2, 4'h8, 4'hF, 4'h3, 4'h8};
    logic [7:0] te[5] = '{8'hFA, 8'hC8, 8'h00, 8'h0F, 8'h40};
    for (int i = 0; i < 5; i++) run_op(tm[i], tq[i], te[i], $sformatf("pattern%0d", i));
  endtask

  task automatic test_ignore_start;
    int d0;
    #1 d0 = n_done;
    @(negedge clk);
    multiplicand = 4'd3;
    multiplier   = 4'd2;
    start        = 1'b1;
    sb.push_back(8'h06);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    multiplicand = 4'd7;
    multiplier   = 4'd7;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    multiplicand = 4'h8;
    multiplier   = 4'h8;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    n_checks++;
    if (n_done - d0 !== 1) begin
      n_errors++;
      $display("FAIL ignore_done_count: got %0d expected 1", n_done - d0);
    end
    n_checks++;
    if (product !== 8'h06 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ignore_held: product=%h busy=%b expected 06/0", product, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int d0;
    #1 d0 = n_done;
    @(negedge clk);
    multiplicand = 4'd3;
    multiplier   = 4'd2;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, product} !== 10'd0) begin
      n_errors++;
      $display("FAIL async_reset: busy=%b done=%b product=%h expected 0/0/00", busy, done, product);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    n_checks++;
    if (n_done !== d0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_no_done: dones=%0d busy=%b expected 0/0", n_done - d0, busy);
    end
    run_op(4'd5, 4'hF, 8'hFB, "after_reset");
  endtask

  task automatic test_back_to_back;
    int last = -1;
    int cnt = 0;
    @(negedge clk);
    multiplicand = 4'd2;
    multiplier   = 4'd3;
    start        = 1'b1;
    repeat (4) sb.push_back(8'h06);
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (i == 19) start = 1'b0;
      if (done === 1'b1) begin
        n_checks++;
        if (product !== 8'h06) begin
          n_errors++;
          $display("FAIL b2b_product_%0d: got %h expected 06", cnt, product);
        end
        if (last >= 0) begin
          n_checks++;
          if (i - last !== 6) begin
            n_errors++;
            $display("FAIL b2b_interval_%0d: got %0d expected 6", cnt, i - last);
          end
        end
        last = i;
        cnt++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (cnt !== 4) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d expected 4", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
